// File: rtl/flit_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : flit_pattern_gen
// Brief    : Packetised thermometer-code flit source for adder operand buses.
//            Optional macro FLITGEN_HOLD_EN: hold last flit on outputs when idle.
// Revision : 1.0 - initial release
// ============================================================================
module flit_pattern_gen #(
  parameter int N       = 27,
  parameter int PAYLOAD = 20,
  parameter int GAP     = 7,
  parameter int PACKETS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] out_lo,
  output logic [N-1:0] out_hi,
  output logic         busy,
  output logic         done
);

  localparam int unsigned C_W      = 2 * N;
  localparam int unsigned C_FOUR_N = 4 * N;
  localparam int unsigned C_FW     = $clog2(PAYLOAD + 1);
  localparam int unsigned C_GW     = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int unsigned C_PW     = (PACKETS > 1) ? $clog2(PACKETS) : 1;

`ifdef FLITGEN_HOLD_EN
  localparam bit C_HOLD_EN = 1'b1;
`else
  localparam bit C_HOLD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [C_FW-1:0]   r_flit,  w_flit_nxt;
  logic [C_GW-1:0]   r_gap,   w_gap_nxt;
  logic [C_PW-1:0]   r_pkt,   w_pkt_nxt;
  logic [C_W-1:0]    r_pat,   w_pat_nxt;

  // Fill phase: top P bits set; drain phase: top (P-2N) bits cleared.
  function automatic logic [C_W-1:0] pat_of(input logic [C_FW-1:0] k);
    logic [C_W-1:0] ones;
    int unsigned    p;
    ones = '1;
    p    = 32'(k) % C_FOUR_N;
    if (p <= C_W) pat_of = ~(ones >> p);
    else          pat_of = ones >> (p - C_W);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_flit_nxt  = r_flit;
    w_gap_nxt   = r_gap;
    w_pkt_nxt   = r_pkt;
    w_pat_nxt   = r_pat;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SEND;
          w_pkt_nxt   = '0;
          w_flit_nxt  = C_FW'(1);
          w_pat_nxt   = pat_of(C_FW'(1));
        end
      end
      S_SEND: begin
        if (out_ready) begin
          if (r_flit == C_FW'(PAYLOAD)) begin
            if (r_pkt == C_PW'(PACKETS - 1)) begin
              w_state_nxt = S_DONE;
            end else if (GAP == 0) begin
              w_pkt_nxt  = r_pkt + C_PW'(1);
              w_flit_nxt = C_FW'(1);
              w_pat_nxt  = pat_of(C_FW'(1));
            end else begin
              w_state_nxt = S_GAP;
              w_gap_nxt   = '0;
            end
          end else begin
            w_flit_nxt = r_flit + C_FW'(1);
            w_pat_nxt  = pat_of(r_flit + C_FW'(1));
          end
        end
      end
      S_GAP: begin
        // Gap length is time-based; out_ready has no effect here.
        if (r_gap == C_GW'(GAP - 1)) begin
          w_state_nxt = S_SEND;
          w_pkt_nxt   = r_pkt + C_PW'(1);
          w_flit_nxt  = C_FW'(1);
          w_pat_nxt   = pat_of(C_FW'(1));
        end else begin
          w_gap_nxt = r_gap + C_GW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (!C_HOLD_EN && (w_state_nxt != S_SEND)) w_pat_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_flit  <= '0;
      r_gap   <= '0;
      r_pkt   <= '0;
      r_pat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_flit  <= w_flit_nxt;
      r_gap   <= w_gap_nxt;
      r_pkt   <= w_pkt_nxt;
      r_pat   <= w_pat_nxt;
    end
  end

  assign out_valid = (r_state == S_SEND);
  assign busy      = (r_state == S_SEND) || (r_state == S_GAP);
  assign done      = (r_state == S_DONE);
  assign out_lo    = r_pat[N-1:0];
  assign out_hi    = r_pat[C_W-1:N];

endmodule
`default_nettype wire

// File: doc/flit_pattern_gen.md
# flit_pattern_gen

Synthesizable stimulus source that drives the two operand buses of the adder under energy characterization. It emits packets of thermometer-coded flits (ones filling from the MSB, then zeros draining from the MSB) with a fixed inter-packet gap. This reproduces the switching-activity profile used for per-bit-width energy estimation in hardware rather than in bench-only code. Sits directly upstream of the adder; its `out_lo`/`out_hi` connect to the adder's `input1`/`input2`.

## Interface
Parameters:
- `N`, 27, operand width; the generated pattern is 2N bits.
- `PAYLOAD`, 20, flits per packet (≥1).
- `GAP`, 7, idle cycles between packets (≥0).
- `PACKETS`, 10, packets per run (≥1).

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  run request, sampled only in IDLE.
- `out_ready`  in  1  downstream accepts the current flit.
- `out_valid`  out  1  `out_lo`/`out_hi` hold a valid flit.
- `out_lo`  out  N  pattern bits [N-1:0] (to adder `input1`).
- `out_hi`  out  N  pattern bits [2N-1:N] (to adder `input2`).
- `busy`  out  1  high in SEND or GAP.
- `done`  out  1  one-cycle pulse when the run completes.

## Operation
- Pattern index k, with P = k mod 4N:
  - P in 0..2N: top P bits are 1, the rest are 0.
  - P in 2N+1..4N-1: top (P−2N) bits are 0, the rest are 1.
- Flit j of a packet (j = 1..PAYLOAD) uses k = j. The index restarts at 1 for every packet.
- FSM states:
  - IDLE: `start`=1 → SEND, with packet counter 0 and flit counter 1.
  - SEND: `out_valid`=1. Each cycle with `out_valid && out_ready`, the flit counter increments.
  - Last flit accepted:
    - If this was the last packet → DONE.
    - Else if GAP=0 → SEND for the next packet, flit 1.
    - Else → GAP.
  - GAP: `out_valid`=0 for exactly GAP cycles; the gap counter runs regardless of `out_ready`. Then → SEND, packet counter +1, flit 1.
  - DONE: `done`=1 for one cycle → IDLE.
- `out_ready`=0 in SEND stalls the flit. `out_lo`/`out_hi` stay stable until the flit is accepted.
- `start` in any state other than IDLE is ignored.
- Counter widths are sized with $clog2 of PAYLOAD+1, GAP+1 and PACKETS. Pattern arithmetic uses 2N-bit masks; nothing is truncated.

## Timing
- Reset values: `out_valid`=0, `out_lo`=0, `out_hi`=0, `busy`=0, `done`=0; state IDLE; all counters 0.
- Latency: `start` sampled high at edge t → flit 1 is on the outputs with `out_valid`=1 during cycle t+1.
- All outputs are registered; no combinational path from `start` or `out_ready` to any output.
- Reset asserted mid-run: the next edge forces the reset values. A `done` pulse is not issued.
- Run length with `out_ready` held at 1:
  - PACKETS·PAYLOAD + (PACKETS−1)·GAP cycles of `busy`, then one `done` cycle.
  - With defaults: 200 + 63 = 263 cycles.

## Configuration
- `FLITGEN_HOLD_EN`
  - Defined: in GAP, IDLE and DONE, `out_lo`/`out_hi` hold the last driven flit, so the adder sees no toggling while idle.
  - Undefined: `out_lo`/`out_hi` are driven to 0 whenever `out_valid`=0. This matches the zero-operand idle condition of the characterization runs.

## Test plan
- Defaults, `out_ready`=1, pulse `start`:
  - flit 1: `out_hi`=27'h4000000, `out_lo`=0.
  - flit 20: `out_hi`=27'h7FFFF80, `out_lo`=0.
  - `out_valid` low for exactly 7 cycles between packets.
  - `done` pulses once, 263 cycles after the first valid flit.
- PAYLOAD=110, N=27, PACKETS=1:
  - flit 54: `out_hi`=`out_lo`=27'h7FFFFFF.
  - flit 55: `out_hi`=27'h3FFFFFF, `out_lo`=27'h7FFFFFF.
  - flit 108: both 0.
  - flit 109: `out_hi`=27'h4000000.
- Stall: drop `out_ready` for 5 cycles at flit 3. Outputs stay at `out_hi`=27'h7000000 for those cycles; flit 4 follows; total run is 5 cycles longer.
- `rst_n`=0 for one cycle at packet 4, flit 10:
  - next cycle all outputs 0, `busy`=0, no `done`.
  - a new `start` restarts at packet 0, flit 1.
- `start` held high throughout the run: exactly one run; the next run begins only from IDLE after `done`.
- Build with and without `FLITGEN_HOLD_EN`: during the gap, outputs equal 27'h7FFFF80/0 vs. 0/0 respectively.
